// File: rtl/femto_rst_seq.sv
// Reset sequencer for femtoPLL consumers: syncs lock, holds, then
// releases peripheral reset followed by core reset after a stagger.
module femto_rst_seq #(
  parameter int freq    = 60,
  parameter int HOLD_US = 100,
  parameter int STAGGER = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_locked,
  input  logic       soft_reset,
  output logic       periph_reset,
  output logic       core_reset,
  output logic       ready,
  output logic [7:0] lock_loss_cnt
);

  localparam int HOLD_CYCLES = freq * HOLD_US;
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int SW = $clog2(STAGGER + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0] STAG_LAST = SW'(STAGGER - 1);

  typedef enum logic [1:0] {
    S_WAIT,
    S_HOLD,
    S_STAG,
    S_RUN
  } state_t;

  state_t        state, nxt;
  logic          s1, locked_s;
  logic [HW-1:0] hcnt, hcnt_n;
  logic [SW-1:0] scnt, scnt_n;
  logic          loss;

  always_comb begin
    nxt    = state;
    hcnt_n = hcnt;
    scnt_n = '0;
    loss   = 1'b0;
    unique case (state)
      S_WAIT: begin
        hcnt_n = '0;
        if (locked_s) begin
          if (HOLD_CYCLES == 1) begin
            nxt = S_STAG;
          end else begin
            nxt    = S_HOLD;
            hcnt_n = HW'(1);
          end
        end
      end
      S_HOLD: begin
        if (!locked_s) begin
          nxt    = S_WAIT;
          hcnt_n = '0;
        end else if (hcnt == HOLD_LAST) begin
          nxt    = S_STAG;
          hcnt_n = '0;
        end else begin
          hcnt_n = hcnt + HW'(1);
        end
      end
      S_STAG: begin
        scnt_n = scnt + SW'(1);
        if (!locked_s) begin
          nxt    = S_WAIT;
          scnt_n = '0;
        end else if (soft_reset) begin
          nxt    = S_HOLD;
          hcnt_n = '0;
          scnt_n = '0;
        end else if (scnt == STAG_LAST) begin
          nxt    = S_RUN;
          scnt_n = '0;
        end
      end
      S_RUN: begin
        if (!locked_s) begin
          nxt  = S_WAIT;
          loss = 1'b1;
        end else if (soft_reset) begin
          nxt    = S_HOLD;
          hcnt_n = '0;
        end
      end
      default: nxt = S_WAIT;
    endcase
  end

  // Outputs are registered from the next state so they change on
  // the same edge as the state transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_WAIT;
      s1            <= 1'b0;
      locked_s      <= 1'b0;
      hcnt          <= '0;
      scnt          <= '0;
      periph_reset  <= 1'b1;
      core_reset    <= 1'b1;
      ready         <= 1'b0;
      lock_loss_cnt <= '0;
    end else begin
      s1           <= pll_locked;
      locked_s     <= s1;
      state        <= nxt;
      hcnt         <= hcnt_n;
      scnt         <= scnt_n;
      periph_reset <= (nxt == S_WAIT) || (nxt == S_HOLD);
      core_reset   <= (nxt != S_RUN);
      ready        <= (state == S_STAG) && (nxt == S_RUN);
      if (loss && lock_loss_cnt != 8'hFF)
        lock_loss_cnt <= lock_loss_cnt + 8'd1;
    end
  end

endmodule
